core_ctrl: RTL and testbench
============================

Name: core_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It owns the PC and instruction register and steps each instruction through fetch, decode, execute, memory and writeback around the combinational ALU. It drives the instruction-memory and data-memory request/ack handshakes and the register-file write enable. It applies the ALU's branch/jump decision to the PC and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word address; PC advances by 1 per instruction).
TIMEOUT, 255, maximum wait cycles for any memory ack before a fault halt; range 1..255.

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address, equals pc
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
instr  out  32  instruction register, feeds the decoder
dec_is_load  in  1  decoder: load instruction
dec_is_store  in  1  decoder: store instruction
dec_wb_en  in  1  decoder: instruction writes rd
dec_halt  in  1  decoder: ebreak/ecall/illegal
alu_pc_load  in  1  ALU: take branch/jump
alu_new_pc  in  32  ALU: branch/jump target
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ack  in  1  data access complete; load data valid this cycle
rf_we  out  1  register-file write enable
pc  out  32  current program counter
instret  out  32  retired-instruction count
halted  out  1  core stopped (sticky until reset)
fault  out  1  stopped due to memory timeout (sticky)

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0, halted=0, fault=0, wait counter=0. All request and enable outputs are 0 while rst is high.
- State machine: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. imem_req, dmem_req, dmem_we, rf_we and halted are decoded combinationally from the state.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, next state DECODE. Otherwise stay in FETCH.
- DECODE: one cycle; decoder outputs settle. If dec_halt=1, next state HALT and instret is unchanged. Otherwise next state EXECUTE.
- EXECUTE: one cycle; ALU outputs settle. If dec_is_load or dec_is_store, next state MEM, else WRITEBACK.
- MEM: dmem_req=1, dmem_we=dec_is_store. Held until dmem_ack, then next state WRITEBACK.
- WRITEBACK (one cycle):
  - rf_we = dec_wb_en & ~dec_is_store.
  - pc <= alu_pc_load ? alu_new_pc : pc+1, modulo 2^32; wrap from FFFF_FFFF to 0 is silent.
  - instret <= instret+1, wraps silently.
  - Next state FETCH.
- Handshake rules:
  - Requests are level signals, held until ack.
  - Ack is sampled only in FETCH (imem) or MEM (dmem); an ack in any other state is ignored.
  - An ack in the first request cycle completes the access with zero wait.
- Latency with zero-wait memory: ALU/branch instruction = 4 cycles, load/store = 5. Each wait cycle adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and on every ack.
  - It increments each cycle in FETCH/MEM without ack.
  - If it equals TIMEOUT with no ack, next state HALT and fault<=1.
- HALT: all requests and rf_we are 0, halted=1; pc and instret are frozen. Only rst exits HALT.
- Reset mid-transaction: the outstanding request drops at once and the access is not retried. After reset release, fetch restarts at RESET_PC on the next clock.
- The PC, instr and decoder flags stay stable from DECODE through WRITEBACK, so the ALU's combinational outputs are valid when sampled.

Decomposition:
- Package core_pkg holds:
  - ctrl_state_t enum
  - NOP_INSTR constant (32'h0000_0013)
  - default RESET_PC
  - TIMEOUT width constant (8 bits)
- One sub-module, wait_timer: 8-bit clear/increment counter with a terminal-count flag, sharing rst.

Test Plan:
- Reset with RESET_PC=0x10, zero-wait imem, instr ADDI (dec_wb_en=1) -> imem_addr=0x10; rf_we pulses in cycle 4; pc=0x11, instret=1.
- imem_ack delayed 3 cycles -> imem_req high for 4 cycles, instr loaded on the ack cycle; total instruction = 7 cycles.
- Branch with alu_pc_load=1, alu_new_pc=0x40 -> pc=0x40 after WRITEBACK. Repeat with alu_pc_load=0 -> pc=old+1; pc=FFFF_FFFF wraps to 0.
- Store (dec_is_store=1, dec_wb_en=1), dmem_ack after 2 cycles -> dmem_req=dmem_we=1 for 3 cycles, rf_we stays 0. Load -> dmem_we=0, rf_we=1 in WRITEBACK.
- TIMEOUT=4, imem_ack never asserted -> halted=1 and fault=1 after 5 FETCH cycles; requests low; stray acks ignored; pc frozen.
- dec_halt=1 in DECODE -> halted=1, fault=0, instret unchanged. rst asserted mid-MEM -> dmem_req drops in the same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } ctrl_state_t;

  // addi x0, x0, 0 -- the instruction register holds this until the first fetch
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          TIMER_W          = 8;

endpackage

// File: rtl/core_ctrl_if.sv
// Instruction- and data-memory request/ack handshake bundle.
interface core_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/core_ctrl_wait_timer.sv
// Memory wait counter: clears or increments, flags when the limit is reached.
module wait_timer
  import core_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  // Count wait cycles; clear has priority so an ack restarts the budget
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LIMIT);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer: fetch, decode, execute, memory, writeback around the ALU.
module core_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  core_ctrl_if.master        bus,
  output logic [31:0]        instr,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_wb_en,
  input  logic               dec_halt,
  input  logic               alu_pc_load,
  input  logic [31:0]        alu_new_pc,
  output logic               rf_we,
  output logic [31:0]        pc,
  output logic [31:0]        instret,
  output logic               halted,
  output logic               fault
);

  ctrl_state_t state, state_nxt;
  logic        in_wait;
  logic        ack_now;
  logic        tmo;
  logic        fault_set;

  // Only FETCH and MEM wait on memory; acks elsewhere are ignored
  assign in_wait = (state == ST_FETCH) || (state == ST_MEM);
  assign ack_now = ((state == ST_FETCH) && bus.imem_ack) ||
                   ((state == ST_MEM)   && bus.dmem_ack);

  // Cleared outside the wait states, so it is already zero on entry
  wait_timer #(
    .LIMIT (TIMER_W'(TIMEOUT))
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (!in_wait || ack_now),
    .inc (in_wait && !ack_now),
    .tc  (tmo)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision and fault detection
  always_comb begin
    state_nxt = state;
    fault_set = 1'b0;
    case (state)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          state_nxt = ST_DECODE;
        end else if (tmo) begin
          state_nxt = ST_HALT;
          fault_set = 1'b1;
        end
      end
      ST_DECODE:    state_nxt = dec_halt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_nxt = (dec_is_load || dec_is_store) ? ST_MEM : ST_WRITEBACK;
      ST_MEM: begin
        if (bus.dmem_ack) begin
          state_nxt = ST_WRITEBACK;
        end else if (tmo) begin
          state_nxt = ST_HALT;
          fault_set = 1'b1;
        end
      end
      ST_WRITEBACK: state_nxt = ST_FETCH;
      ST_HALT:      state_nxt = ST_HALT;
      default:      state_nxt = ST_HALT;
    endcase
  end

  // Requests and enables are gated by rst so they drop the moment reset rises
  assign bus.imem_req  = !rst && (state == ST_FETCH);
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = !rst && (state == ST_MEM);
  assign bus.dmem_we   = !rst && (state == ST_MEM) && dec_is_store;
  assign rf_we         = !rst && (state == ST_WRITEBACK) && dec_wb_en && !dec_is_store;
  assign halted        = (state == ST_HALT);

  // Architectural state: instruction register, PC, retire count, sticky fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      instr   <= NOP_INSTR;
      instret <= '0;
      fault   <= 1'b0;
    end else begin
      if ((state == ST_FETCH) && bus.imem_ack) begin
        instr <= bus.imem_rdata;
      end
      if (state == ST_WRITEBACK) begin
        pc      <= alu_pc_load ? alu_new_pc : pc + 32'd1;
        instret <= instret + 32'd1;
      end
      if (fault_set) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl with an instruction-level timeline model.
module tb_core_ctrl;
  import core_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0010;
  localparam int          TO  = 4;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        halted;
    logic        fault;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        dec_is_load, dec_is_store, dec_wb_en, dec_halt;
  logic        alu_pc_load;
  logic [31:0] alu_new_pc;
  logic        rf_we;
  logic [31:0] pc, instret;
  logic        halted, fault;

  core_ctrl_if bus ();

  core_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .instr        (instr),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_wb_en    (dec_wb_en),
    .dec_halt     (dec_halt),
    .alu_pc_load  (alu_pc_load),
    .alu_new_pc   (alu_new_pc),
    .rf_we        (rf_we),
    .pc           (pc),
    .instret      (instret),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ncyc   = 0;
  exp_t exp_q[$];
  exp_t ce;

  // Architectural model
  logic [31:0] m_pc, m_instret, m_instr;
  logic        m_halted, m_fault;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    e         = '0;
    e.addr    = m_pc;
    e.pc      = m_pc;
    e.instret = m_instret;
    e.instr   = m_instr;
    e.halted  = m_halted;
    e.fault   = m_fault;
    return e;
  endfunction

  // Compare DUT outputs against the expectation for this cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      chk("imem_req",  {31'd0, bus.imem_req}, {31'd0, ce.imem_req});
      chk("imem_addr", bus.imem_addr,         ce.addr);
      chk("dmem_req",  {31'd0, bus.dmem_req}, {31'd0, ce.dmem_req});
      chk("dmem_we",   {31'd0, bus.dmem_we},  {31'd0, ce.dmem_we});
      chk("rf_we",     {31'd0, rf_we},        {31'd0, ce.rf_we});
      chk("halted",    {31'd0, halted},       {31'd0, ce.halted});
      chk("fault",     {31'd0, fault},        {31'd0, ce.fault});
      chk("pc",        pc,                    ce.pc);
      chk("instret",   instret,               ce.instret);
      chk("instr",     instr,                 ce.instr);
    end
  end

  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    m_pc      = RPC;
    m_instret = '0;
    m_instr   = NOP_INSTR;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
    cyc(mk());
    cyc(mk());
    rst = 1'b0;
  endtask

  task automatic rnd_acks();
    bus.imem_ack   = 1'($urandom_range(0, 1));
    bus.dmem_ack   = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      rnd_acks();
      cyc(mk());
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // One instruction; wf/wd are wait cycles (beyond TO means no ack ever)
  task automatic run_instr(input int wf, input logic [31:0] rd, input bit ld, input bit st,
                           input bit wb, input bit hlt, input int wd, input bit pl,
                           input logic [31:0] npc, input bit rst_mem, output bit stopped);
    exp_t e;
    stopped      = 1'b0;
    dec_is_load  = 1'($urandom_range(0, 1));
    dec_is_store = 1'($urandom_range(0, 1));
    dec_wb_en    = 1'($urandom_range(0, 1));
    dec_halt     = 1'($urandom_range(0, 1));
    alu_pc_load  = 1'($urandom_range(0, 1));
    alu_new_pc   = $urandom;
    for (int k = 0; k <= TO; k++) begin
      bus.imem_ack   = (k == wf);
      bus.imem_rdata = (k == wf) ? rd : $urandom;
      bus.dmem_ack   = 1'($urandom_range(0, 1));
      e = mk();
      e.imem_req = 1'b1;
      cyc(e);
      if (k == wf) break;
    end
    bus.imem_ack = 1'b0;
    if (wf > TO) begin
      m_halted = 1'b1;
      m_fault  = 1'b1;
      stopped  = 1'b1;
      return;
    end
    m_instr      = rd;
    dec_is_load  = ld;
    dec_is_store = st;
    dec_wb_en    = wb;
    dec_halt     = hlt;
    alu_pc_load  = pl;
    alu_new_pc   = npc;
    rnd_acks();
    cyc(mk());
    if (hlt) begin
      m_halted = 1'b1;
      stopped  = 1'b1;
      return;
    end
    dec_halt = 1'b0;
    rnd_acks();
    cyc(mk());
    if (ld || st) begin
      for (int k = 0; k <= TO; k++) begin
        if (rst_mem && k == 1) begin
          do_reset();
          stopped = 1'b1;
          return;
        end
        bus.dmem_ack = (k == wd);
        bus.imem_ack = 1'($urandom_range(0, 1));
        e = mk();
        e.dmem_req = 1'b1;
        e.dmem_we  = st;
        cyc(e);
        if (k == wd) break;
      end
      if (wd > TO) begin
        bus.dmem_ack = 1'b0;
        m_halted = 1'b1;
        m_fault  = 1'b1;
        stopped  = 1'b1;
        return;
      end
    end
    rnd_acks();
    e = mk();
    e.rf_we = wb && !st;
    cyc(e);
    m_pc      = pl ? npc : m_pc + 32'd1;
    m_instret = m_instret + 32'd1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit  s;
    int  start;
    bit  ld, st;
    logic [31:0] keep;
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;
    dec_is_load = 0; dec_is_store = 0; dec_wb_en = 0; dec_halt = 0;
    alu_pc_load = 0; alu_new_pc = '0;
    @(posedge clk);
    #1;
    do_reset();

    // ADDI, zero-wait fetch
    start = ncyc;
    run_instr(0, 32'h0010_0093, 0, 0, 1, 0, 0, 0, 0, 0, s);
    chk("lat_alu", ncyc - start, 4);
    chk("pc_after_addi", pc, 32'h0000_0011);
    chk("instret_after_addi", instret, 32'd1);

    // Fetch ack after 3 wait cycles
    start = ncyc;
    run_instr(3, 32'h0020_0113, 0, 0, 1, 0, 0, 0, 0, 0, s);
    chk("lat_fetch_wait3", ncyc - start, 7);
    chk("instr_loaded", instr, 32'h0020_0113);

    // Branch taken, then not taken
    run_instr(0, 32'h0000_0063, 0, 0, 0, 0, 0, 1, 32'h0000_0040, 0, s);
    chk("pc_branch", pc, 32'h0000_0040);
    run_instr(1, 32'h0000_0063, 0, 0, 0, 0, 0, 0, 32'h0000_0080, 0, s);
    chk("pc_not_taken", pc, 32'h0000_0041);

    // PC wrap
    run_instr(0, 32'h0000_006f, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 0, s);
    run_instr(0, 32'h0000_0013, 0, 0, 1, 0, 0, 0, 0, 0, s);
    chk("pc_wrap", pc, 32'h0000_0000);

    // Store with 2 wait cycles, load zero-wait
    start = ncyc;
    run_instr(0, 32'h0020_a023, 0, 1, 1, 0, 2, 0, 0, 0, s);
    chk("lat_store_wait2", ncyc - start, 7);
    start = ncyc;
    run_instr(0, 32'h0000_a083, 1, 0, 1, 0, 0, 0, 0, 0, s);
    chk("lat_load", ncyc - start, 5);

    // Ack exactly at the wait limit still completes
    run_instr(TO, 32'h0030_0193, 1, 0, 1, 0, TO, 0, 0, 0, s);
    chk("no_fault_at_limit", {31'd0, fault}, 32'd0);

    // Random instruction mix
    for (int i = 0; i < 150; i++) begin
      ld = ($urandom_range(0, 3) == 0);
      st = !ld && ($urandom_range(0, 3) == 0);
      run_instr($urandom_range(0, TO), $urandom, ld, st, 1'($urandom_range(0, 1)), 0,
                $urandom_range(0, TO), ($urandom_range(0, 3) == 0), $urandom, 0, s);
    end

    // Decoder halt
    keep = m_instret;
    run_instr(0, 32'h0010_0073, 0, 0, 0, 1, 0, 0, 0, 0, s);
    hold_halt(5);
    chk("halt_instret_frozen", instret, keep);
    chk("halt_no_fault", {31'd0, fault}, 32'd0);
    chk("halt_set", {31'd0, halted}, 32'd1);

    // Fetch timeout
    do_reset();
    start = ncyc;
    run_instr(99, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, s);
    chk("tmo_fetch_cycles", ncyc - start, 5);
    hold_halt(6);
    chk("tmo_halted", {31'd0, halted}, 32'd1);
    chk("tmo_fault", {31'd0, fault}, 32'd1);
    chk("tmo_pc_frozen", pc, 32'h0000_0010);

    // Reset in the middle of a memory access
    do_reset();
    run_instr(0, 32'h0000_a083, 1, 0, 1, 0, 3, 0, 0, 1, s);
    chk("rst_mem_pc", pc, 32'h0000_0010);
    run_instr(0, 32'h0010_0093, 0, 0, 1, 0, 0, 0, 0, 0, s);
    chk("after_rst_pc", pc, 32'h0000_0011);

    // Data-memory timeout
    run_instr(1, 32'h0020_a023, 0, 1, 1, 0, 99, 0, 0, 0, s);
    hold_halt(4);
    chk("dtmo_fault", {31'd0, fault}, 32'd1);
    do_reset();
    run_instr(2, 32'h0010_0093, 0, 0, 1, 0, 0, 0, 0, 0, s);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
